// File: rtl/ramp_fir_filter.sv
// ramp_fir_filter
//   Streaming ramp (FIR) filter for one projection line at a time. Each line of
//   pLineLength raw samples produces exactly pLineLength filtered samples. The
//   output is aligned to the filter's centre tap, so the group delay is removed.
//   Samples outside the line are treated as zero.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   clear      synchronous abort to IDLE (coefficients are kept)
//   coef_we    coefficient write strobe (IDLE only)
//   coef_addr  tap index k
//   coef_data  h[k], signed
//   in_valid   input sample valid
//   in_ready   input sample accepted when in_valid && in_ready
//   in_data    raw input sample, signed
//   out_valid  output sample valid
//   out_ready  downstream accepts when out_valid && out_ready
//   out_data   filtered, saturated sample, signed
//   out_last   marks the final sample of a line
//   busy       high whenever the line engine is not IDLE
module ramp_fir_filter #(
  parameter int pDataLength         = 8,
  parameter int pFilteredDataLength = 12,
  parameter int pCoeffLength        = 8,
  parameter int pOrder              = 8,
  parameter int pShift              = 0,
  parameter int pLineLength         = 256,
  localparam int AW = (pOrder > 0) ? $clog2(pOrder + 1) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  clear,
  input  logic                                  coef_we,
  input  logic [AW-1:0]                         coef_addr,
  input  logic signed [pCoeffLength-1:0]        coef_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [pDataLength-1:0]         in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [pFilteredDataLength-1:0] out_data,
  output logic                                  out_last,
  output logic                                  busy
);

  localparam int NT   = pOrder + 1;
  localparam int H    = pOrder / 2;
  localparam int ACCW = pDataLength + pCoeffLength + $clog2(pOrder + 1);
  localparam int OW   = pFilteredDataLength;
  localparam int SW   = ((ACCW > OW) ? ACCW : OW) + 1;
  localparam int CW   = (pLineLength > 1) ? $clog2(pLineLength) : 1;
  localparam int FW   = (H > 0) ? $clog2(H + 1) : 1;
  localparam int LAST = pLineLength - 1;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic signed [pCoeffLength-1:0] COEF_ONE = pCoeffLength'(1 << pShift);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  function automatic logic signed [ACCW-1:0] ashr_acc(input logic signed [ACCW-1:0] v);
    return v >>> pShift;
  endfunction

  function automatic logic signed [OW-1:0] sat_out(input logic signed [ACCW-1:0] v);
    logic signed [SW-1:0] ext;
    ext = SW'(v);
    if (ext > SAT_MAX)      ext = SAT_MAX;
    else if (ext < SAT_MIN) ext = SAT_MIN;
    return ext[OW-1:0];
  endfunction

  state_t state, state_nx;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [FW-1:0] fl_cnt;

  logic signed [pCoeffLength-1:0] coef   [NT];
  logic signed [pDataLength-1:0]  tap_p0 [NT];
  logic signed [pDataLength-1:0]  tap_nx [NT];
  logic signed [ACCW-1:0]         acc;
  logic signed [OW-1:0]           y_p1;
  logic                           vld_p1;

  logic can_step, in_rdy, accept, flush_step, produce;

  // Handshake and step control
  always_comb begin
    can_step = !vld_p1 || out_ready;
    in_rdy   = 1'b0;
    case (state)
      IDLE:     in_rdy = !coef_we && can_step;
      FILL:     in_rdy = can_step;
      RUN:      in_rdy = can_step;
      default:  in_rdy = 1'b0;
    endcase
    // Held low while reset is asserted so the port shows its reset value.
    in_ready   = in_rdy && reset_n;
    accept     = in_valid && in_ready;
    flush_step = (state == FLUSH) && can_step;
    produce    = flush_step || (accept && (int'(in_cnt) >= H));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FILL, RUN: begin
        if (accept) begin
          if (int'(in_cnt) == LAST)     state_nx = (H == 0) ? IDLE : FLUSH;
          else if (int'(in_cnt) + 1 >= H) state_nx = RUN;
          else                            state_nx = FILL;
        end
      end
      FLUSH: begin
        if (flush_step && (int'(fl_cnt) == H - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: tap register contents after this step. A line's first sample
  // (accepted in IDLE) sees an all-zero history; FLUSH shifts in zeros.
  always_comb begin
    tap_nx    = '{default: '0};
    tap_nx[0] = accept ? in_data : '0;
    for (int k = 1; k < NT; k++)
      tap_nx[k] = (state == IDLE) ? '0 : tap_p0[k-1];
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < NT; k++)
      acc = acc + (ACCW'(coef[k]) * ACCW'(tap_nx[k]));
  end

  // Control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      fl_cnt  <= '0;
      vld_p1  <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      fl_cnt  <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept)
        in_cnt <= (int'(in_cnt) == LAST) ? '0 : in_cnt + 1'b1;
      // out_cnt is the line index of the sample currently in the output register.
      if (vld_p1 && out_ready)
        out_cnt <= (int'(out_cnt) == LAST) ? '0 : out_cnt + 1'b1;
      if (flush_step)
        fl_cnt <= (int'(fl_cnt) == H - 1) ? '0 : fl_cnt + 1'b1;
      if (produce)        vld_p1 <= 1'b1;
      else if (out_ready) vld_p1 <= 1'b0;
    end
  end

  // Coefficients survive clear; reset restores the identity response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NT; k++)
        coef[k] <= (k == H) ? COEF_ONE : '0;
    end else if (!clear && (state == IDLE) && coef_we && (int'(coef_addr) <= pOrder)) begin
      coef[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tap_p0 <= '{default: '0};
    end else if (clear) begin
      tap_p0 <= '{default: '0};
    end else if (accept || flush_step) begin
      tap_p0 <= tap_nx;
    end
  end

  // Stage p1: output register, loaded on the producing step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     y_p1 <= '0;
    else if (clear)   y_p1 <= y_p1;
    else if (produce) y_p1 <= sat_out(ashr_acc(acc));
  end

  assign out_valid = vld_p1;
  assign out_data  = y_p1;
  assign out_last  = vld_p1 && (int'(out_cnt) == LAST);
  assign busy      = (state != IDLE);

endmodule
